// File: rtl/uart_rx_sink.sv
// 8N1 UART receiver feeding a one-deep valid/ready holding register.
// Flags stop-bit frame errors and bytes dropped because the holder was still full.
module uart_rx_sink #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       io_mainClk,
  input  logic       io_asyncResetn,
  input  logic       io_uart_rxd,
  output logic [7:0] io_data_payload,
  output logic       io_data_valid,
  input  logic       io_data_ready,
  output logic       io_frameError,
  output logic       io_overrun,
  output logic       io_busy,
  output logic [2:0] dbg_state
);

  if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_bad_param
    $error("uart_rx_sink: CLKS_PER_BIT must be in 4..65535");
  end

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      sync_q;
  logic            rxs;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      payload_q;
  logic            valid_q;
  logic            fe_q;
  logic            ov_q;
  logic            commit;
  logic            frame_err;
  logic            accept;

  assign rxs = sync_q[1];

  always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      sync_q  <= {sync_q[0], io_uart_rxd};
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // The timer counts cycles since the last sample point; START waits half a
  // bit so every later sample lands mid-bit.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + TW'(1);
    bit_d     = bit_q;
    shift_d   = shift_q;
    commit    = 1'b0;
    frame_err = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (!rxs) state_d = START;
      end
      START: begin
        if (timer_q == T_HALF) begin
          timer_d = '0;
          if (rxs) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            bit_d   = '0;
          end
        end
      end
      DATA: begin
        if (timer_q == T_FULL) begin
          timer_d = '0;
          shift_d = {rxs, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (timer_q == T_FULL) begin
          timer_d = '0;
          if (rxs) begin
            commit  = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err = 1'b1;
            state_d   = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        timer_d = '0;
        if (rxs) state_d = IDLE;
      end
      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Handshake: a byte transfers on any edge where valid && ready. valid holds
  // the payload stable until then; a commit in the same cycle as a transfer
  // refills the holder, otherwise a commit into a full holder is an overrun.
  assign accept = valid_q && io_data_ready;

  always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      payload_q <= 8'h00;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      fe_q <= frame_err;
      ov_q <= commit && valid_q && !io_data_ready;
      if (commit && (!valid_q || io_data_ready)) begin
        payload_q <= shift_q;
        valid_q   <= 1'b1;
      end else if (accept) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign io_data_payload = payload_q;
  assign io_data_valid   = valid_q;
  assign io_frameError   = fe_q;
  assign io_overrun      = ov_q;
  assign io_busy         = (state_q != IDLE);
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_uart_rx_sink.sv
// Directed bench for uart_rx_sink at 8 clocks per bit; a monitor drains a
// scoreboard queue on every accepted byte and tallies error/busy pulses.
module tb_uart_rx_sink;

  localparam int C = 8;

  logic       clk;
  logic       rst_n;
  logic       rxd;
  logic [7:0] payload;
  logic       valid;
  logic       ready;
  logic       fe;
  logic       ov;
  logic       busy;
  logic [2:0] dbg_state;

  uart_rx_sink #(.CLKS_PER_BIT(C)) dut (
    .io_mainClk      (clk),
    .io_asyncResetn  (rst_n),
    .io_uart_rxd     (rxd),
    .io_data_payload (payload),
    .io_data_valid   (valid),
    .io_data_ready   (ready),
    .io_frameError   (fe),
    .io_overrun      (ov),
    .io_busy         (busy),
    .dbg_state       (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int valid_cnt = 0, busy_cnt = 0, fe_cnt = 0, ov_cnt = 0;
  int rise_cyc = 0;
  int last_start = 0;
  logic prev_v = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // monitor / scoreboard
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (valid && !prev_v) rise_cyc = cyc;
      prev_v = valid;
      if (valid) valid_cnt++;
      if (busy)  busy_cnt++;
      if (fe)    fe_cnt++;
      if (ov)    ov_cnt++;
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected actual=%02h required=none", payload);
        end else begin
          chk("sb_payload", 32'(payload), 32'(exp_q.pop_front()));
        end
      end
    end
  endtask

  // driver tasks (called just after a rising edge)
  task automatic hold_line(input logic b, input int n);
    rxd = b;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    last_start = cyc;
    hold_line(1'b0, C);
    for (int i = 0; i < 8; i++) hold_line(d[i], C);
    hold_line(stop_bit, C);
    rxd = 1'b1;
  endtask

  int b_v, b_fe, b_ov, b_busy, lat;

  initial begin
    rst_n = 1'b0;
    rxd   = 1'b1;
    ready = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk("rst_payload", 32'(payload), 32'h00);
    chk("rst_valid",   32'(valid),   32'h0);
    chk("rst_fe",      32'(fe),      32'h0);
    chk("rst_ov",      32'(ov),      32'h0);
    chk("rst_busy",    32'(busy),    32'h0);
    chk("rst_state",   32'(dbg_state), 32'h0);
    rst_n = 1'b1;
    hold_line(1'b1, 4);

    // 1: single byte, ready high
    ready = 1'b1;
    b_v = valid_cnt; b_fe = fe_cnt; b_ov = ov_cnt;
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1);
    hold_line(1'b1, 6);
    chk("s1_valid_cycles", 32'(valid_cnt - b_v), 1);
    lat = rise_cyc - last_start;
    checks++;
    if (!(lat inside {79, 80})) begin
      failures++;
      $display("FAIL s1_latency actual=%0d required=79..80", lat);
    end
    chk("s1_fe", 32'(fe_cnt - b_fe), 0);
    chk("s1_ov", 32'(ov_cnt - b_ov), 0);

    // 2: back-to-back with ready low -> overrun, first byte held
    ready = 1'b0;
    b_ov = ov_cnt; b_fe = fe_cnt;
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h81, 1'b1);
    hold_line(1'b1, 4);
    chk("s2_ov", 32'(ov_cnt - b_ov), 1);
    chk("s2_fe", 32'(fe_cnt - b_fe), 0);
    chk("s2_valid_held", 32'(valid), 1);
    chk("s2_payload_held", 32'(payload), 32'h3C);
    ready = 1'b1;
    hold_line(1'b1, 1);
    ready = 1'b0;
    hold_line(1'b1, 2);
    chk("s2_valid_drop", 32'(valid), 0);

    // 3: false start glitch
    b_busy = busy_cnt; b_v = valid_cnt; b_fe = fe_cnt;
    hold_line(1'b0, 2);
    hold_line(1'b1, 12);
    chk("s3_busy_cycles", 32'(busy_cnt - b_busy), 4);
    chk("s3_valid", 32'(valid_cnt - b_v), 0);
    chk("s3_fe", 32'(fe_cnt - b_fe), 0);
    chk("s3_idle", 32'(busy), 0);

    // 4: bad stop bit then long break, then a good byte
    ready = 1'b1;
    b_v = valid_cnt; b_fe = fe_cnt;
    send_byte(8'h55, 1'b0);
    hold_line(1'b0, 40);
    chk("s4_busy_in_break", 32'(busy), 1);
    chk("s4_fe", 32'(fe_cnt - b_fe), 1);
    hold_line(1'b1, 5);
    chk("s4_busy_after", 32'(busy), 0);
    chk("s4_valid", 32'(valid_cnt - b_v), 0);
    exp_q.push_back(8'h12);
    send_byte(8'h12, 1'b1);
    hold_line(1'b1, 4);

    // 5: reset mid-DATA with a byte held
    ready = 1'b0;
    send_byte(8'h77, 1'b1);
    hold_line(1'b1, 2);
    chk("s5_pre_valid", 32'(valid), 1);
    chk("s5_pre_payload", 32'(payload), 32'h77);
    hold_line(1'b0, C);
    hold_line(1'b1, 12);
    chk("s5_pre_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("s5_rst_valid", 32'(valid), 0);
    chk("s5_rst_payload", 32'(payload), 32'h00);
    chk("s5_rst_busy", 32'(busy), 0);
    chk("s5_rst_fe", 32'(fe), 0);
    chk("s5_rst_ov", 32'(ov), 0);
    hold_line(1'b1, 3);
    rst_n = 1'b1;
    hold_line(1'b1, 20);
    b_fe = fe_cnt;
    ready = 1'b1;
    exp_q.push_back(8'hF0);
    send_byte(8'hF0, 1'b1);
    hold_line(1'b1, 4);
    chk("s5_fe", 32'(fe_cnt - b_fe), 0);

    // 6: accept in the exact commit cycle of the next byte
    ready = 1'b0;
    b_ov = ov_cnt;
    exp_q.push_back(8'h11);
    send_byte(8'h11, 1'b1);
    hold_line(1'b1, 4);
    exp_q.push_back(8'h22);
    fork
      send_byte(8'h22, 1'b1);
      begin
        repeat (78) begin
          @(posedge clk);
          #1;
        end
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
      end
    join
    chk("s6_ov", 32'(ov_cnt - b_ov), 0);
    chk("s6_valid", 32'(valid), 1);
    chk("s6_payload", 32'(payload), 32'h22);
    ready = 1'b1;
    hold_line(1'b1, 1);
    ready = 1'b0;
    hold_line(1'b1, 2);
    chk("s6_valid_drop", 32'(valid), 0);
    chk("sb_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
